// File: rtl/led_blink_coder_if.sv
// Indicator/fault inputs and LED/frame outputs of the status-LED blink coder.
interface led_blink_coder_if #(
    parameter int unsigned N_CH = 4
) ();
    logic [N_CH-1:0] ind;
    logic            fault_in;
    logic            led;
    logic            frame_start;

    // Driver side: indicator bank and fault source.
    modport master (
        output ind,
        output fault_in,
        input  led,
        input  frame_start
    );

    // Coder side.
    modport slave (
        input  ind,
        input  fault_in,
        output led,
        output frame_start
    );
endinterface

// File: rtl/led_blink_coder.sv
// Serialises N_CH activity indicators onto one status LED as a repeating
// long/short blink code, with a synchronised fault input that overrides
// the code with a fast square wave.
module led_blink_coder #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned TICK_DIV    = 640000,
    parameter int unsigned SHORT_TICKS = 5,
    parameter int unsigned LONG_TICKS  = 25,
    parameter int unsigned SLOT_TICKS  = 40,
    parameter int unsigned GAP_TICKS   = 100,
    parameter int unsigned FAULT_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    led_blink_coder_if.slave   bus
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned TMAX_GS = (GAP_TICKS > SLOT_TICKS) ? GAP_TICKS : SLOT_TICKS;
    localparam int unsigned TMAX    = (TMAX_GS > FAULT_TICKS) ? TMAX_GS : FAULT_TICKS;
    localparam int unsigned TCNT_W  = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_SLOT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    logic [PRESC_W-1:0] r_presc;
    logic               r_fault_meta;
    logic               r_fault_s;
    state_t             r_state;
    logic [TCNT_W-1:0]  r_tcnt;
    logic [IDX_W-1:0]   r_idx;
    logic [N_CH-1:0]    r_mask;
    logic               r_phase;
    logic               r_led;
    logic               r_frame_start;

    logic               w_tick;
    logic [TCNT_W-1:0]  w_on_len;
    logic               w_led_next;

    assign w_tick     = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_on_len   = r_mask[r_idx] ? TCNT_W'(LONG_TICKS) : TCNT_W'(SHORT_TICKS);
    assign w_led_next = ((r_state == ST_SLOT) && (r_tcnt < w_on_len)) ||
                        ((r_state == ST_FAULT) && r_phase);

    assign bus.led         = r_led;
    assign bus.frame_start = r_frame_start;

    // Free-running tick prescaler, independent of the coder state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous fault flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_meta <= 1'b0;
            r_fault_s    <= 1'b0;
        end else begin
            r_fault_meta <= bus.fault_in;
            r_fault_s    <= r_fault_meta;
        end
    end

    // Gap/slot/fault sequencer with registered LED and frame-start outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_GAP;
            r_tcnt        <= '0;
            r_idx         <= '0;
            r_mask        <= '0;
            r_phase       <= 1'b0;
            r_led         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_led         <= w_led_next;
            if (r_fault_s && (r_state != ST_FAULT)) begin
                // Fault preempts everything, including a pending frame start.
                r_state <= ST_FAULT;
                r_tcnt  <= '0;
                r_phase <= 1'b1;
            end else if (!r_fault_s && (r_state == ST_FAULT)) begin
                // Leaving fault restarts with a full gap before the next frame.
                r_state <= ST_GAP;
                r_tcnt  <= '0;
                r_idx   <= '0;
            end else if (w_tick) begin
                case (r_state)
                    ST_GAP: begin
                        if (r_tcnt == TCNT_W'(GAP_TICKS - 1)) begin
                            r_state       <= ST_SLOT;
                            r_tcnt        <= '0;
                            r_idx         <= '0;
                            r_mask        <= ~bus.ind;
                            r_frame_start <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
                    end
                    ST_SLOT: begin
                        if (r_tcnt == TCNT_W'(SLOT_TICKS - 1)) begin
                            r_tcnt <= '0;
                            if (r_idx == IDX_W'(N_CH - 1)) begin
                                r_state <= ST_GAP;
                                r_idx   <= '0;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
                    end
                    default: begin
                        if (r_tcnt == TCNT_W'(FAULT_TICKS - 1)) begin
                            r_tcnt  <= '0;
                            r_phase <= ~r_phase;
                        end else begin
                            r_tcnt <= r_tcnt + TCNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
